lcd_controller: RTL and testbench
=================================

# lcd_controller

Responder end of the LCD control handshake: accepts one byte at a time (data or command) over a four-phase req/ack interface from the LCD bus interface and drives an HD44780-compatible panel in 8-bit, write-only mode. It sequences RS/data setup, the E strobe and the post-write execution delay, then acknowledges. It sits between the bus-side LCD interface and the board's LCD pins.

## Interface
- SETUP_CYCLES, 2: cycles RS/data stable before E rises.
- E_PULSE_CYCLES, 25: cycles E held high.
- CMD_WAIT_CYCLES, 2500: post-strobe wait for normal writes.
- CLEAR_WAIT_CYCLES, 100000: post-strobe wait for commands 0x01/0x02 and every init command.
- POWERON_CYCLES, 1000000: post-reset wait before init (init builds only).

- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- ctrl_data  input  8  byte to write; sampled at acceptance.
- ctrl_data_is_cmd  input  1  1 = command (RS=0), 0 = data (RS=1); sampled at acceptance.
- ctrl_data_req  input  1  request level from the bus interface.
- ctrl_data_ack  output  1  acknowledge level.
- lcd_rs  output  1  register select.
- lcd_rw  output  1  constant 0.
- lcd_e  output  1  enable strobe.
- lcd_data  output  8  panel data bus.
- ready  output  1  1 when in IDLE.

## Operation
- Reset values: ctrl_data_ack=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, ready=0.
- States: PWR_WAIT, INIT, IDLE, SETUP, PULSE, WAIT, ACK. One down-counter sized to $clog2 of the largest parameter plus 1, shared by all timed states.
- IDLE: ready=1. On ctrl_data_req=1, latch byte into lcd_data, set lcd_rs = !ctrl_data_is_cmd, go SETUP.
- SETUP: E=0 for SETUP_CYCLES, then PULSE.
- PULSE: E=1 for E_PULSE_CYCLES, then E=0 and WAIT.
- WAIT: CLEAR_WAIT_CYCLES if the byte is a command equal to 0x01 or 0x02, otherwise CMD_WAIT_CYCLES; then ACK.
- ACK: ack=1 while req=1. When req=0, ack=0 next cycle, go IDLE. If req is already 0 on entry (protocol violation), ack is never raised; go IDLE directly.
- A new request is never accepted until ack has returned low (strict four-phase).
- lcd_data/lcd_rs hold their last values after a transfer.
- req asserted while in PWR_WAIT/INIT: held off, no ack until init completes and that transfer finishes.
- Reset mid-transfer: all outputs return to reset values the cycle after rst is sampled high; E drops immediately; the pending request is dropped; init restarts (init builds).

## Timing
- Acceptance: req sampled high in IDLE at edge N; lcd_data/lcd_rs valid at N+1.
- E rises at N+1+SETUP_CYCLES, falls E_PULSE_CYCLES later.
- ack rises at N+1+SETUP_CYCLES+E_PULSE_CYCLES+wait.
- ack falls one cycle after req sampled low; ready rises the same cycle.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- LCD_INIT_SEQ_EN defined: after reset, PWR_WAIT for POWERON_CYCLES, then INIT sends commands 0x30, 0x30, 0x30, 0x38, 0x0C, 0x01, 0x06 (RS=0), each with full SETUP/PULSE timing and CLEAR_WAIT_CYCLES wait, no ack; then IDLE.
- Not defined: PWR_WAIT and INIT are not built; IDLE the cycle after reset; software performs the panel init.

## Test plan
- Params 2/4/10/50/100, no init: req with data 0x41, is_cmd=0 -> lcd_rs=1, lcd_data=0x41, E high exactly 4 cycles starting 2 cycles after latch, ack 10 cycles after E falls, held until req drops, low one cycle later.
- Command 0x01 -> lcd_rs=0, wait 50 cycles; command 0x80 -> wait 10 cycles.
- Init build: after reset, no E for 100 cycles, then seven E pulses carrying 0x30,0x30,0x30,0x38,0x0C,0x01,0x06; req raised at cycle 5 acked only after the seventh pulse and its own transfer.
- Back-to-back: req held high through ack then dropped and immediately re-raised with 0x42 -> second byte accepted only after ack low; exactly two E pulses.
- rst asserted during PULSE -> E=0, ack=0, lcd_data=0x00 the next cycle; no ack for the aborted byte.
- req dropped during WAIT -> no ack pulse; ready=1 after WAIT ends.

Source files
------------

// File: rtl/lcd_controller_if.sv
// Four-phase req/ack byte channel from the bus-side LCD interface to lcd_controller.
// The master drives the byte and holds req high; the slave answers with an ack level.
interface lcd_controller_if;
  logic [7:0] ctrl_data;
  logic       ctrl_data_is_cmd;
  logic       ctrl_data_req;
  logic       ctrl_data_ack;

  modport master (
    output ctrl_data, ctrl_data_is_cmd, ctrl_data_req,
    input  ctrl_data_ack
  );

  modport slave (
    input  ctrl_data, ctrl_data_is_cmd, ctrl_data_req,
    output ctrl_data_ack
  );
endinterface

// File: rtl/lcd_controller.sv
// HD44780 8-bit write sequencer: latch byte, setup, E strobe, execution wait, then four-phase ack.
// All outputs registered; LCD_INIT_SEQ_EN adds a power-on wait plus the fixed panel init sequence.
module lcd_controller #(
  parameter int SETUP_CYCLES      = 2,
  parameter int E_PULSE_CYCLES    = 25,
  parameter int CMD_WAIT_CYCLES   = 2500,
  parameter int CLEAR_WAIT_CYCLES = 100000,
  parameter int POWERON_CYCLES    = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  lcd_controller_if.slave ctrl,
  output logic            lcd_rs,
  output logic            lcd_rw,
  output logic            lcd_e,
  output logic [7:0]      lcd_data,
  output logic            ready
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = max2(max2(max2(SETUP_CYCLES, E_PULSE_CYCLES),
                                  max2(CMD_WAIT_CYCLES, CLEAR_WAIT_CYCLES)), POWERON_CYCLES);
  localparam int CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(E_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] CMD_LD   = CW'(CMD_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_WAIT_CYCLES - 1);

`ifdef LCD_INIT_SEQ_EN
  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, SETUP, PULSE, WAIT, ACK} state_e;
  localparam state_e        RST_STATE = PWR_WAIT;
  localparam logic [CW-1:0] RST_CNT   = CW'(POWERON_CYCLES - 1);
`else
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, WAIT, ACK} state_e;
  localparam state_e        RST_STATE = IDLE;
  localparam logic [CW-1:0] RST_CNT   = '0;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          e_q, e_d;
  logic          ack_q, ack_d;
  logic          ready_q, ready_d;
  logic          clear_wait;

`ifdef LCD_INIT_SEQ_EN
  logic       init_q, init_d;
  logic [2:0] idx_q, idx_d;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return 8'h30;
      3'd3:             return 8'h38;
      3'd4:             return 8'h0C;
      3'd5:             return 8'h01;
      default:          return 8'h06;
    endcase
  endfunction

  assign clear_wait = init_q || (!rs_q && (data_q == 8'h01 || data_q == 8'h02));
`else
  assign clear_wait = !rs_q && (data_q == 8'h01 || data_q == 8'h02);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    e_d     = e_q;
    ack_d   = ack_q;
`ifdef LCD_INIT_SEQ_EN
    init_d  = init_q;
    idx_d   = idx_q;
`endif
    unique case (state_q)
`ifdef LCD_INIT_SEQ_EN
      PWR_WAIT: begin
        if (cnt_q == '0) state_d = INIT;
        else             cnt_d   = cnt_q - CW'(1);
      end
      INIT: begin
        data_d  = init_byte(idx_q);
        rs_d    = 1'b0;
        cnt_d   = SETUP_LD;
        state_d = SETUP;
      end
`endif
      IDLE: begin
        // ready_q gates the very first cycle after reset, before ready is visible
        if (ready_q && ctrl.ctrl_data_req) begin
          data_d  = ctrl.ctrl_data;
          rs_d    = !ctrl.ctrl_data_is_cmd;
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          e_d     = 1'b1;
          cnt_d   = PULSE_LD;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          e_d     = 1'b0;
          cnt_d   = clear_wait ? CLEAR_LD : CMD_LD;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
`ifdef LCD_INIT_SEQ_EN
        end else if (init_q) begin
          if (idx_q == 3'd6) begin
            init_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = INIT;
          end
`endif
        end else if (ctrl.ctrl_data_req) begin
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          // requester already withdrew: skip the ack phase entirely
          state_d = IDLE;
        end
      end
      ACK: begin
        if (!ctrl.ctrl_data_req) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= RST_CNT;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      ack_q   <= 1'b0;
      ready_q <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
      init_q  <= 1'b1;
      idx_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      ack_q   <= ack_d;
      ready_q <= ready_d;
`ifdef LCD_INIT_SEQ_EN
      init_q  <= init_d;
      idx_q   <= idx_d;
`endif
    end
  end

  assign ctrl.ctrl_data_ack = ack_q;
  assign lcd_rs             = rs_q;
  assign lcd_rw             = 1'b0;
  assign lcd_e              = e_q;
  assign lcd_data           = data_q;
  assign ready              = ready_q;

endmodule

// File: tb/tb_lcd_controller.sv
// Bench for lcd_controller with short timing parameters; E-pulse monitor checks against a queue of expected writes.
module tb_lcd_controller;
  localparam int S  = 2;
  localparam int P  = 4;
  localparam int WC = 10;
  localparam int WL = 50;
  localparam int PO = 100;

  typedef struct {
    logic [7:0] data;
    logic       is_cmd;
    logic       rs;
    int         wait_c;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         wait_c;
    bit         chk_setup;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;
  logic lcd_rs, lcd_rw, lcd_e, ready;
  logic [7:0] lcd_data;

  lcd_controller_if bus ();

  lcd_controller #(
    .SETUP_CYCLES     (S),
    .E_PULSE_CYCLES   (P),
    .CMD_WAIT_CYCLES  (WC),
    .CLEAR_WAIT_CYCLES(WL),
    .POWERON_CYCLES   (PO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl    (bus),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_e   (lcd_e),
    .lcd_data(lcd_data),
    .ready   (ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_s <= rst;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every E pulse must match the oldest expected write and its timing.
  int   cyc = 0, acc_cyc = 0, rise_cyc = 0, fall_cyc = 0;
  int   pulses = 0, ack_rises = 0;
  bit   e_prev = 0, ack_prev = 0, rdy_prev = 0, in_pulse = 0, fall_vld = 0;
  exp_t cur;

  always @(negedge clk) begin
    cyc++;
    if (rst_s) begin
      in_pulse = 0;
      fall_vld = 0;
    end
    if (ready !== 1'b1 && rdy_prev) acc_cyc = cyc;
    if (lcd_e === 1'b1 && !e_prev) begin
      pulses++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'(pulses), 32'(0));
      end else begin
        cur = sb.pop_front();
        chk("pulse_data", 32'(lcd_data), 32'(cur.data));
        chk("pulse_rs", 32'(lcd_rs), 32'(cur.rs));
        if (cur.chk_setup) chk("setup_cycles", 32'(cyc - acc_cyc), 32'(S));
      end
      rise_cyc = cyc;
      in_pulse = 1;
    end
    if (lcd_e !== 1'b1 && e_prev && in_pulse) begin
      chk("e_width", 32'(cyc - rise_cyc), 32'(P));
      fall_cyc = cyc;
      fall_vld = 1;
      in_pulse = 0;
    end
    if (bus.ctrl_data_ack === 1'b1 && !ack_prev) begin
      ack_rises++;
      if (fall_vld) chk("ack_delay", 32'(cyc - fall_cyc), 32'(cur.wait_c));
      else          chk("spurious_ack", 32'(1), 32'(0));
      fall_vld = 0;
    end
    e_prev   = (lcd_e === 1'b1);
    ack_prev = (bus.ctrl_data_ack === 1'b1);
    rdy_prev = (ready === 1'b1);
  end

  task automatic wait_ack(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (bus.ctrl_data_ack === 1'b1) break;
      @(negedge clk);
    end
    if (bus.ctrl_data_ack !== 1'b1) chk("ack_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_e(input logic lvl, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (lcd_e === lvl) break;
      @(negedge clk);
    end
    if (lcd_e !== lvl) chk("e_timeout", 32'(lcd_e), 32'(lvl));
  endtask

  task automatic push_exp(input logic [7:0] d, input logic rs, input int w, input bit cs);
    exp_t e;
    e.data = d; e.rs = rs; e.wait_c = w; e.chk_setup = cs;
    sb.push_back(e);
  endtask

  task automatic do_xfer(input logic [7:0] d, input logic c, input logic rs, input int w, input int hold);
    push_exp(d, rs, w, 1);
    @(negedge clk);
    bus.ctrl_data = d; bus.ctrl_data_is_cmd = c; bus.ctrl_data_req = 1'b1;
    @(negedge clk);
    chk("accept_data", 32'(lcd_data), 32'(d));
    chk("accept_rs", 32'(lcd_rs), 32'(rs));
    chk("busy_ready", 32'(ready), 32'(0));
    wait_ack(200);
    repeat (hold) begin
      @(negedge clk);
      chk("ack_held", 32'(bus.ctrl_data_ack), 32'(1));
    end
    bus.ctrl_data_req = 1'b0;
    @(negedge clk);
    chk("ack_fall", 32'(bus.ctrl_data_ack), 32'(0));
    chk("ready_rise", 32'(ready), 32'(1));
    chk("data_hold", 32'(lcd_data), 32'(d));
  endtask

  vec_t vecs[5];
  int   p0, a0;

  initial begin
    vecs[0] = '{8'h41, 1'b0, 1'b1, WC};
    vecs[1] = '{8'h01, 1'b1, 1'b0, WL};
    vecs[2] = '{8'h80, 1'b1, 1'b0, WC};
    vecs[3] = '{8'h02, 1'b1, 1'b0, WL};
    vecs[4] = '{8'h01, 1'b0, 1'b1, WC};

    bus.ctrl_data = 8'h00; bus.ctrl_data_is_cmd = 1'b0; bus.ctrl_data_req = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(bus.ctrl_data_ack), 32'(0));
    chk("rst_e", 32'(lcd_e), 32'(0));
    chk("rst_rs", 32'(lcd_rs), 32'(0));
    chk("rst_rw", 32'(lcd_rw), 32'(0));
    chk("rst_data", 32'(lcd_data), 32'(0));
    chk("rst_ready", 32'(ready), 32'(0));
    rst = 1'b0;

`ifdef LCD_INIT_SEQ_EN
    push_exp(8'h30, 1'b0, WL, 0);
    push_exp(8'h30, 1'b0, WL, 0);
    push_exp(8'h30, 1'b0, WL, 0);
    push_exp(8'h38, 1'b0, WL, 0);
    push_exp(8'h0C, 1'b0, WL, 0);
    push_exp(8'h01, 1'b0, WL, 0);
    push_exp(8'h06, 1'b0, WL, 0);
    push_exp(8'h41, 1'b1, WC, 1);
    repeat (5) @(negedge clk);
    bus.ctrl_data = 8'h41; bus.ctrl_data_is_cmd = 1'b0; bus.ctrl_data_req = 1'b1;
    repeat (PO - 5) @(negedge clk);
    chk("poweron_quiet", 32'(pulses), 32'(0));
    wait_ack(1000);
    chk("init_plus_host_pulses", 32'(pulses), 32'(8));
    bus.ctrl_data_req = 1'b0;
    @(negedge clk);
    chk("init_ack_fall", 32'(bus.ctrl_data_ack), 32'(0));
`else
    @(negedge clk);
    chk("ready_after_rst", 32'(ready), 32'(1));
`endif

    foreach (vecs[i]) do_xfer(vecs[i].data, vecs[i].is_cmd, vecs[i].rs, vecs[i].wait_c, 2);

    // back-to-back: second request raised right after ack returns low
    p0 = pulses;
    do_xfer(8'h33, 1'b0, 1'b1, WC, 3);
    do_xfer(8'h42, 1'b0, 1'b1, WC, 0);
    chk("b2b_pulses", 32'(pulses - p0), 32'(2));

    // requester withdraws during the execution wait
    a0 = ack_rises;
    push_exp(8'h55, 1'b1, WC, 1);
    @(negedge clk);
    bus.ctrl_data = 8'h55; bus.ctrl_data_is_cmd = 1'b0; bus.ctrl_data_req = 1'b1;
    wait_e(1'b1, 20);
    wait_e(1'b0, 20);
    bus.ctrl_data_req = 1'b0;
    @(negedge clk);
    chk("withdraw_busy", 32'(ready), 32'(0));
    repeat (WC + 2) @(negedge clk);
    chk("withdraw_no_ack", 32'(ack_rises), 32'(a0));
    chk("withdraw_ready", 32'(ready), 32'(1));

`ifndef LCD_INIT_SEQ_EN
    // reset while E is high
    a0 = ack_rises;
    push_exp(8'h77, 1'b1, WC, 1);
    @(negedge clk);
    bus.ctrl_data = 8'h77; bus.ctrl_data_is_cmd = 1'b0; bus.ctrl_data_req = 1'b1;
    wait_e(1'b1, 20);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_e", 32'(lcd_e), 32'(0));
    chk("abort_ack", 32'(bus.ctrl_data_ack), 32'(0));
    chk("abort_data", 32'(lcd_data), 32'(0));
    chk("abort_rs", 32'(lcd_rs), 32'(0));
    rst = 1'b0;
    bus.ctrl_data_req = 1'b0;
    repeat (WL) @(negedge clk);
    chk("abort_no_ack", 32'(ack_rises), 32'(a0));
    chk("abort_ready", 32'(ready), 32'(1));
`endif

    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
